// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular instruction queue between fetch and decode. Accepts
//               one 32-bit instruction pair per cycle, presents the two
//               oldest 16-bit entries with their PC and PC+1, and lets decode
//               retire 0..2 entries per cycle. Branch flush discards contents.
//               Optional macro FETCH_QUEUE_PERF_EN adds a saturating stall
//               counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push_valid,
    input  logic [31:0]                i_push_inst,
    input  logic [15:0]                i_push_pc,
    output logic                       o_push_ready,
    input  logic [1:0]                 i_pop_req,
    input  logic                       i_flush,
    output logic                       o_out0_valid,
    output logic                       o_out1_valid,
    output logic [15:0]                o_out0_inst,
    output logic [15:0]                o_out1_inst,
    output logic [15:0]                o_out0_pc,
    output logic [15:0]                o_out1_pc,
    output logic [15:0]                o_out0_pc_plus1,
    output logic [15:0]                o_out1_pc_plus1,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [15:0]                o_stall_count,
`endif
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_READY_MAX = CW'(DEPTH - 2);

    // Each entry is {pc, inst}
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic [1:0]    w_pop_req;
    logic [1:0]    w_pops;
    logic [AW-1:0] w_tail1;
    logic [AW-1:0] w_head1;
    logic [15:0]   w_push_pc1;
    logic [31:0]   w_ent0;
    logic [31:0]   w_ent1;

    // Ready depends only on registered occupancy: room for a full pair
    assign o_push_ready = (r_count <= c_READY_MAX);
    assign w_push       = i_push_valid && o_push_ready && !i_flush;
    assign w_tail1      = r_tail + AW'(1);
    assign w_head1      = r_head + AW'(1);
    assign w_push_pc1   = i_push_pc + 16'd1;

    // Clip the pop request to 2 and then to what is actually held
    always_comb begin
        w_pop_req = (i_pop_req == 2'd3) ? 2'd2 : i_pop_req;
        w_pops    = w_pop_req;
        if (r_count < CW'(w_pop_req)) begin
            w_pops = r_count[1:0];
        end
    end

    // Pointer and occupancy update; flush overrides push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pops);
            if (w_push) begin
                r_tail <= r_tail + AW'(2);
            end
            r_count <= r_count + (w_push ? CW'(2) : CW'(0)) - CW'(w_pops);
        end
    end

    // Entry storage is written only on push and carries no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail]  <= {i_push_pc, i_push_inst[15:0]};
            r_mem[w_tail1] <= {w_push_pc1, i_push_inst[31:16]};
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] r_stall_count;

    // Count cycles where fetch offered a pair but the queue was full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (i_push_valid && !o_push_ready && !i_flush &&
                     (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign o_stall_count = r_stall_count;
`endif

    assign w_ent0       = r_mem[r_head];
    assign w_ent1       = r_mem[w_head1];
    assign o_out0_valid = (r_count != '0);
    assign o_out1_valid = (r_count > CW'(1));
    assign o_count      = r_count;

    // Head outputs read zero whenever the slot is not occupied
    always_comb begin
        o_out0_inst     = 16'h0000;
        o_out0_pc       = 16'h0000;
        o_out0_pc_plus1 = 16'h0000;
        o_out1_inst     = 16'h0000;
        o_out1_pc       = 16'h0000;
        o_out1_pc_plus1 = 16'h0000;
        if (o_out0_valid) begin
            o_out0_inst     = w_ent0[15:0];
            o_out0_pc       = w_ent0[31:16];
            o_out0_pc_plus1 = w_ent0[31:16] + 16'd1;
        end
        if (o_out1_valid) begin
            o_out1_inst     = w_ent1[15:0];
            o_out1_pc       = w_ent1[31:16];
            o_out1_pc_plus1 = w_ent1[31:16] + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        push_valid;
    logic [31:0] push_inst;
    logic [15:0] push_pc;
    logic        push_ready;
    logic [1:0]  pop_req;
    logic        flush;
    logic        out0_valid, out1_valid;
    logic [15:0] out0_inst, out1_inst, out0_pc, out1_pc;
    logic [15:0] out0_pc_plus1, out1_pc_plus1;
    logic [3:0]  count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_push_valid    (push_valid),
        .i_push_inst     (push_inst),
        .i_push_pc       (push_pc),
        .o_push_ready    (push_ready),
        .i_pop_req       (pop_req),
        .i_flush         (flush),
        .o_out0_valid    (out0_valid),
        .o_out1_valid    (out1_valid),
        .o_out0_inst     (out0_inst),
        .o_out1_inst     (out1_inst),
        .o_out0_pc       (out0_pc),
        .o_out1_pc       (out1_pc),
        .o_out0_pc_plus1 (out0_pc_plus1),
        .o_out1_pc_plus1 (out1_pc_plus1),
`ifdef FETCH_QUEUE_PERF_EN
        .o_stall_count   (stall_count),
`endif
        .o_count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [15:0] pc, input logic [31:0] inst,
                         input logic [1:0] pr, input logic fl);
        push_valid = pv;
        push_pc    = pc;
        push_inst  = inst;
        pop_req    = pr;
        flush      = fl;
    endtask

    initial begin
        logic [15:0] pc;
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 32'h0, 2'd0, 1'b0);
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_v0", 32'(out0_valid), 32'd0);
        chk("rst_v1", 32'(out1_valid), 32'd0);
        chk("rst_ready", 32'(push_ready), 32'd1);
        chk("rst_out0_inst", 32'(out0_inst), 32'd0);
        chk("rst_out1_pc1", 32'(out1_pc_plus1), 32'd0);
        rst_n = 1'b1;
        step();

        // Scenario 1: single pair push
        drive(1'b1, 16'h0010, 32'hB222_A111, 2'd0, 1'b0);
        step();
        chk("s1_count", 32'(count), 32'd2);
        chk("s1_out0_inst", 32'(out0_inst), 32'hA111);
        chk("s1_out0_pc", 32'(out0_pc), 32'h0010);
        chk("s1_out0_pc1", 32'(out0_pc_plus1), 32'h0011);
        chk("s1_out1_inst", 32'(out1_inst), 32'hB222);
        chk("s1_out1_pc", 32'(out1_pc), 32'h0011);
        chk("s1_out1_pc1", 32'(out1_pc_plus1), 32'h0012);

        // Scenario 2: fill to 8, then a dropped push
        drive(1'b1, 16'h0012, 32'h2222_1111, 2'd0, 1'b0);
        step();
        drive(1'b1, 16'h0014, 32'h4444_3333, 2'd0, 1'b0);
        step();
        drive(1'b1, 16'h0016, 32'h6666_5555, 2'd0, 1'b0);
        step();
        chk("s2_count8", 32'(count), 32'd8);
        chk("s2_ready0", 32'(push_ready), 32'd0);
        drive(1'b1, 16'h0080, 32'hDEAD_BEEF, 2'd0, 1'b0);
        step();
        chk("s2_drop_count", 32'(count), 32'd8);
        chk("s2_head_kept", 32'(out0_inst), 32'hA111);
`ifdef FETCH_QUEUE_PERF_EN
        chk("s2_stall", 32'(stall_count), 32'd1);
`endif

        // Scenario 3: push refused while popping two at full
        drive(1'b1, 16'h0080, 32'hDEAD_BEEF, 2'd2, 1'b0);
        #1;
        chk("s3_ready0", 32'(push_ready), 32'd0);
        step();
        chk("s3_count6", 32'(count), 32'd6);
        chk("s3_out0_pc", 32'(out0_pc), 32'h0012);
        chk("s3_out1_inst", 32'(out1_inst), 32'h2222);

        // pop_req=3 acts as 2
        drive(1'b0, 16'h0, 32'h0, 2'd3, 1'b0);
        step();
        chk("pop3_count", 32'(count), 32'd4);
        chk("pop3_out0_pc", 32'(out0_pc), 32'h0014);
        drive(1'b0, 16'h0, 32'h0, 2'd2, 1'b0);
        step();
        drive(1'b0, 16'h0, 32'h0, 2'd1, 1'b0);
        step();
        chk("pop1_count", 32'(count), 32'd1);
        chk("pop1_out0_pc", 32'(out0_pc), 32'h0017);
        chk("pop1_out0_inst", 32'(out0_inst), 32'h6666);
        chk("pop1_v1", 32'(out1_valid), 32'd0);
        chk("pop1_out1_inst0", 32'(out1_inst), 32'd0);

        // Scenario 4: over-request clipped to occupancy
        drive(1'b0, 16'h0, 32'h0, 2'd2, 1'b0);
        step();
        chk("s4_count0", 32'(count), 32'd0);
        chk("s4_v0", 32'(out0_valid), 32'd0);
        chk("s4_out0_pc0", 32'(out0_pc), 32'd0);
        drive(1'b1, 16'h0040, 32'h2B2B_1A1A, 2'd0, 1'b0);
        step();
        chk("s4_push_count", 32'(count), 32'd2);
        chk("s4_push_inst", 32'(out0_inst), 32'h1A1A);
        chk("s4_push_pc", 32'(out0_pc), 32'h0040);
        chk("s4_push_inst1", 32'(out1_inst), 32'h2B2B);

        // Scenario 5: flush overrides push and pop at count 6
        drive(1'b1, 16'h0042, 32'h0000_0001, 2'd0, 1'b0);
        step();
        drive(1'b1, 16'h0044, 32'h0000_0002, 2'd0, 1'b0);
        step();
        chk("s5_count6", 32'(count), 32'd6);
        drive(1'b1, 16'h0046, 32'h0000_0003, 2'd1, 1'b1);
        step();
        chk("s5_count0", 32'(count), 32'd0);
        chk("s5_v0", 32'(out0_valid), 32'd0);
        chk("s5_v1", 32'(out1_valid), 32'd0);
        chk("s5_ready", 32'(push_ready), 32'd1);

        // Scenario 6: steady push/pop-2 stream wrapping the pointers
        drive(1'b1, 16'h0000, 32'hF00E_0F0F, 2'd0, 1'b0);
        step();
        for (int k = 1; k <= 20; k++) begin
            pc = 16'(2 * k);
            chk("s6_out0_pc", 32'(out0_pc), 32'(pc - 16'd2));
            chk("s6_out0_inst", 32'(out0_inst), 32'((pc - 16'd2) ^ 16'h0F0F));
            chk("s6_out1_inst", 32'(out1_inst), 32'((pc - 16'd1) ^ 16'hF00F));
            drive(1'b1, pc, {pc + 16'd1 ^ 16'hF00F, pc ^ 16'h0F0F}, 2'd2, 1'b0);
            step();
            chk("s6_count", 32'(count), 32'd2);
        end
        chk("s6_last_pc", 32'(out0_pc), 32'd40);

        // Asynchronous reset mid-run, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_count", 32'(count), 32'd0);
        chk("s6_async_v0", 32'(out0_valid), 32'd0);
        chk("s6_async_ready", 32'(push_ready), 32'd1);
        drive(1'b0, 16'h0, 32'h0, 2'd0, 1'b0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 16'h1234, 32'hCCCC_DDDD, 2'd0, 1'b0);
        step();
        chk("post_rst_count", 32'(count), 32'd2);
        chk("post_rst_inst", 32'(out0_inst), 32'hDDDD);
        chk("post_rst_pc", 32'(out0_pc), 32'h1234);
        chk("post_rst_pc1", 32'(out1_pc_plus1), 32'h1236);
        drive(1'b0, 16'h0, 32'h0, 2'd0, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
